// File: rtl/sbox_decrypt_sequencer.sv
// Time-shared 4-bit S-box substitution over a 64-bit state, LANES nibbles per cycle, LSB nibble first.
// Optional macro SBOX_SEQ_FWD_EN adds a per-block fwd input selecting the forward table instead of the inverse.
module sbox_decrypt_sequencer #(
    parameter int BLOCKSIZE = 64,
    parameter int LANES     = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [BLOCKSIZE-1:0] in_data,
`ifdef SBOX_SEQ_FWD_EN
    input  logic                 fwd,
`endif
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [BLOCKSIZE-1:0] out_data,
    output logic                 busy
);

    localparam int NIBBLES = BLOCKSIZE / 4;
    localparam int NGRP    = NIBBLES / LANES;
    localparam int GW      = (NGRP > 1) ? $clog2(NGRP) : 1;
    localparam logic [GW-1:0] LAST_GRP = GW'(NGRP - 1);

    if (BLOCKSIZE != 64) begin : g_badBlockSize
        $error("sbox_decrypt_sequencer: BLOCKSIZE must be 64");
    end
    if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_badLanes
        $error("sbox_decrypt_sequencer: LANES must be 1, 2, 4, 8 or 16");
    end

    typedef enum logic [1:0] {IDLE, SUB, DONE} state_t;

    state_t                 r_state;
    logic [BLOCKSIZE-1:0]   r_work;
    logic [BLOCKSIZE-1:0]   r_outData;
    logic [GW-1:0]          r_grp;
    logic                   r_outValid;
    logic                   r_busy;
    logic [BLOCKSIZE-1:0]   w_subWork;
    logic                   w_accept;
`ifdef SBOX_SEQ_FWD_EN
    logic                   r_mode;
`endif

    function automatic logic [3:0] invSbox(input logic [3:0] n);
        case (n)
            4'h0: invSbox = 4'h5;  4'h1: invSbox = 4'hE;  4'h2: invSbox = 4'hF;  4'h3: invSbox = 4'h8;
            4'h4: invSbox = 4'hC;  4'h5: invSbox = 4'h1;  4'h6: invSbox = 4'h2;  4'h7: invSbox = 4'hD;
            4'h8: invSbox = 4'hB;  4'h9: invSbox = 4'h4;  4'hA: invSbox = 4'h6;  4'hB: invSbox = 4'h3;
            4'hC: invSbox = 4'h0;  4'hD: invSbox = 4'h7;  4'hE: invSbox = 4'h9;  default: invSbox = 4'hA;
        endcase
    endfunction

`ifdef SBOX_SEQ_FWD_EN
    function automatic logic [3:0] fwdSbox(input logic [3:0] n);
        case (n)
            4'h0: fwdSbox = 4'hC;  4'h1: fwdSbox = 4'h5;  4'h2: fwdSbox = 4'h6;  4'h3: fwdSbox = 4'hB;
            4'h4: fwdSbox = 4'h9;  4'h5: fwdSbox = 4'h0;  4'h6: fwdSbox = 4'hA;  4'h7: fwdSbox = 4'hD;
            4'h8: fwdSbox = 4'h3;  4'h9: fwdSbox = 4'hE;  4'hA: fwdSbox = 4'hF;  4'hB: fwdSbox = 4'h8;
            4'hC: fwdSbox = 4'h4;  4'hD: fwdSbox = 4'h7;  4'hE: fwdSbox = 4'h1;  default: fwdSbox = 4'h2;
        endcase
    endfunction
`endif

    // Only the current group's nibbles change; everything else passes through untouched.
    always_comb begin
        w_subWork = r_work;
        for (int l = 0; l < LANES; l++) begin
`ifdef SBOX_SEQ_FWD_EN
            w_subWork[(int'(r_grp) * LANES + l) * 4 +: 4] =
                r_mode ? fwdSbox(r_work[(int'(r_grp) * LANES + l) * 4 +: 4])
                       : invSbox(r_work[(int'(r_grp) * LANES + l) * 4 +: 4]);
`else
            w_subWork[(int'(r_grp) * LANES + l) * 4 +: 4] =
                invSbox(r_work[(int'(r_grp) * LANES + l) * 4 +: 4]);
`endif
        end
    end

    assign in_ready = (r_state == IDLE) || (r_state == DONE && out_ready);
    assign w_accept = in_valid && in_ready;

    // An accept in DONE retires the pending result and starts the next block on the same edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_work     <= '0;
            r_grp      <= '0;
            r_outValid <= 1'b0;
            r_busy     <= 1'b0;
            r_outData  <= '0;
`ifdef SBOX_SEQ_FWD_EN
            r_mode     <= 1'b0;
`endif
        end else if (w_accept) begin
            r_work     <= in_data;
            r_grp      <= '0;
            r_state    <= SUB;
            r_busy     <= 1'b1;
            r_outValid <= 1'b0;
`ifdef SBOX_SEQ_FWD_EN
            r_mode     <= fwd;
`endif
        end else begin
            case (r_state)
                SUB: begin
                    r_work <= w_subWork;
                    if (r_grp == LAST_GRP) begin
                        r_grp      <= '0;
                        r_state    <= DONE;
                        r_busy     <= 1'b0;
                        r_outValid <= 1'b1;
                        r_outData  <= w_subWork;
                    end else begin
                        r_grp <= r_grp + GW'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_outValid <= 1'b0;
                        r_state    <= IDLE;
                    end
                end
                IDLE: ;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign out_valid = r_outValid;
    assign out_data  = r_outData;
    assign busy      = r_busy;

endmodule

// File: tb/tb_sbox_decrypt_sequencer.sv
// Bench for sbox_decrypt_sequencer: a LANES=1 instance (A) and a LANES=16 instance (B) against a table model.
// Define SBOX_SEQ_FWD_EN to also exercise the forward-table mode.
module tb_sbox_decrypt_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        aInValid, aInReady, aOutValid, aOutReady, aBusy, aFwd;
    logic [63:0] aInData, aOutData;
    logic        bInValid, bInReady, bOutValid, bOutReady, bBusy, bFwd;
    logic [63:0] bInData, bOutData;

    int nChecks = 0;
    int nPassed = 0;

    logic [3:0] invTab [16] = '{4'h5, 4'hE, 4'hF, 4'h8, 4'hC, 4'h1, 4'h2, 4'hD,
                                4'hB, 4'h4, 4'h6, 4'h3, 4'h0, 4'h7, 4'h9, 4'hA};
    logic [3:0] fwdTab [16] = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
                                4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};

    always #5 clk = ~clk;

    sbox_decrypt_sequencer #(.BLOCKSIZE(64), .LANES(1)) dutA (
        .clk(clk), .reset(reset),
        .in_valid(aInValid), .in_ready(aInReady), .in_data(aInData),
`ifdef SBOX_SEQ_FWD_EN
        .fwd(aFwd),
`endif
        .out_valid(aOutValid), .out_ready(aOutReady), .out_data(aOutData), .busy(aBusy)
    );

    sbox_decrypt_sequencer #(.BLOCKSIZE(64), .LANES(16)) dutB (
        .clk(clk), .reset(reset),
        .in_valid(bInValid), .in_ready(bInReady), .in_data(bInData),
`ifdef SBOX_SEQ_FWD_EN
        .fwd(bFwd),
`endif
        .out_valid(bOutValid), .out_ready(bOutReady), .out_data(bOutData), .busy(bBusy)
    );

    function automatic logic [63:0] refSub(input logic [63:0] d, input logic fwdMode);
        logic [63:0] r;
        for (int i = 0; i < 16; i++)
            r[i*4 +: 4] = fwdMode ? fwdTab[d[i*4 +: 4]] : invTab[d[i*4 +: 4]];
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one block to A from IDLE, then counts edges until out_valid (capped at 40).
    task automatic runA(input logic [63:0] d, input logic f, output logic [63:0] got, output int lat);
        aInValid = 1'b1; aInData = d; aFwd = f; aOutReady = 1'b0;
        tick();
        aInValid = 1'b0; aInData = {$urandom(), $urandom()}; aFwd = 1'($urandom());
        lat = 0;
        while (!aOutValid && lat < 40) begin
            tick();
            lat++;
        end
        got = aOutData;
    endtask

    task automatic releaseA();
        aOutReady = 1'b1;
        tick();
        aOutReady = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        aInValid = 0; aInData = '0; aOutReady = 0; aFwd = 0;
        bInValid = 0; bInData = '0; bOutReady = 0; bFwd = 0;
        #12;
        nChecks++; if (aOutValid !== 1'b0) $display("[TB] FAIL reset_a_out_valid: got %b want 0", aOutValid); else nPassed++;
        nChecks++; if (aInReady !== 1'b1) $display("[TB] FAIL reset_a_in_ready: got %b want 1", aInReady); else nPassed++;
        nChecks++; if (aOutData !== 64'h0) $display("[TB] FAIL reset_a_out_data: got %h want 0", aOutData); else nPassed++;
        nChecks++; if (aBusy !== 1'b0) $display("[TB] FAIL reset_a_busy: got %b want 0", aBusy); else nPassed++;
        nChecks++; if (bOutValid !== 1'b0 || bInReady !== 1'b1) $display("[TB] FAIL reset_b: valid %b ready %b want 0/1", bOutValid, bInReady); else nPassed++;
        @(posedge clk); #1;
        reset = 1'b0;
        tick();
    endtask

    task automatic test_known_vector();
        aInValid = 1'b1; aInData = 64'h0123456789ABCDEF; aFwd = 1'b0; aOutReady = 1'b0;
        tick();
        aInValid = 1'b0;
        for (int k = 0; k < 16; k++) begin
            nChecks++;
            if (aBusy !== 1'b1 || aOutValid !== 1'b0)
                $display("[TB] FAIL known_busy_window cycle %0d: busy %b valid %b want 1/0", k, aBusy, aOutValid);
            else nPassed++;
            tick();
        end
        nChecks++; if (aOutValid !== 1'b1 || aBusy !== 1'b0) $display("[TB] FAIL known_done_flags: valid %b busy %b want 1/0", aOutValid, aBusy); else nPassed++;
        nChecks++; if (aOutData !== 64'h5EF8C12DB463079A) $display("[TB] FAIL known_data: got %h want 5ef8c12db463079a", aOutData); else nPassed++;
        releaseA();
        nChecks++; if (aOutValid !== 1'b0 || aInReady !== 1'b1) $display("[TB] FAIL known_release: valid %b ready %b want 0/1", aOutValid, aInReady); else nPassed++;
    endtask

    task automatic test_random();
        logic [63:0] d, got, exp;
        logic        f;
        int          lat;
        for (int i = 0; i < 8; i++) begin
            d = {$urandom(), $urandom()};
`ifdef SBOX_SEQ_FWD_EN
            f = 1'($urandom());
`else
            f = 1'b0;
`endif
            exp = refSub(d, f);
            runA(d, f, got, lat);
            nChecks++; if (lat !== 16) $display("[TB] FAIL random_latency %0d: got %0d want 16", i, lat); else nPassed++;
            nChecks++; if (got !== exp) $display("[TB] FAIL random_data %0d: got %h want %h", i, got, exp); else nPassed++;
            repeat ($urandom_range(3)) tick();
            nChecks++; if (aOutValid !== 1'b1 || aOutData !== exp) $display("[TB] FAIL random_hold %0d: valid %b data %h want 1/%h", i, aOutValid, aOutData, exp); else nPassed++;
            releaseA();
        end
    endtask

    task automatic test_stall_reload();
        logic [63:0] d0, got, exp0;
        int          lat;
        d0 = {$urandom(), $urandom()} | 64'h1;
        exp0 = refSub(d0, 1'b0);
        runA(d0, 1'b0, got, lat);
        nChecks++; if (got !== exp0) $display("[TB] FAIL stall_first_data: got %h want %h", got, exp0); else nPassed++;
        for (int k = 0; k < 5; k++) begin
            nChecks++;
            if (aOutValid !== 1'b1 || aOutData !== exp0 || aInReady !== 1'b0)
                $display("[TB] FAIL stall_hold cycle %0d: valid %b data %h ready %b want 1/%h/0", k, aOutValid, aOutData, aInReady, exp0);
            else nPassed++;
            tick();
        end
        aOutReady = 1'b1; aInValid = 1'b1; aInData = 64'h0; aFwd = 1'b0;
        #1;
        nChecks++; if (aInReady !== 1'b1) $display("[TB] FAIL stall_ready_with_out_ready: got %b want 1", aInReady); else nPassed++;
        tick();
        aInValid = 1'b0; aOutReady = 1'b0;
        nChecks++; if (aOutValid !== 1'b0 || aBusy !== 1'b1 || aOutData !== exp0) $display("[TB] FAIL reload_edge: valid %b busy %b data %h want 0/1/%h", aOutValid, aBusy, aOutData, exp0); else nPassed++;
        lat = 0;
        while (!aOutValid && lat < 40) begin
            tick();
            lat++;
        end
        nChecks++; if (lat !== 16) $display("[TB] FAIL reload_latency: got %0d want 16", lat); else nPassed++;
        nChecks++; if (aOutData !== 64'h5555555555555555) $display("[TB] FAIL reload_data: got %h want 5555555555555555", aOutData); else nPassed++;
        releaseA();
    endtask

    task automatic test_reset_abort();
        int seen;
        aInValid = 1'b1; aInData = {$urandom(), $urandom()}; aFwd = 1'b0; aOutReady = 1'b0;
        tick();
        aInValid = 1'b0;
        repeat (7) tick();
        reset = 1'b1;
        #1;
        nChecks++; if (aOutValid !== 1'b0 || aInReady !== 1'b1) $display("[TB] FAIL abort_flags: valid %b ready %b want 0/1", aOutValid, aInReady); else nPassed++;
        nChecks++; if (aOutData !== 64'h0 || aBusy !== 1'b0) $display("[TB] FAIL abort_data: data %h busy %b want 0/0", aOutData, aBusy); else nPassed++;
        @(posedge clk); #1;
        reset = 1'b0;
        aOutReady = 1'b1;
        seen = 0;
        repeat (30) begin
            tick();
            if (aOutValid) seen++;
        end
        aOutReady = 1'b0;
        nChecks++; if (seen !== 0) $display("[TB] FAIL abort_no_output: got %0d valid cycles want 0", seen); else nPassed++;
    endtask

    task automatic test_ignore_in_sub();
        logic [63:0] d1, d2, exp1;
        int          lat, seen;
        d1 = {$urandom(), $urandom()};
        d2 = ~d1;
        exp1 = refSub(d1, 1'b0);
        aInValid = 1'b1; aInData = d1; aFwd = 1'b0; aOutReady = 1'b0;
        tick();
        aInValid = 1'b0;
        tick();
        tick();
        aInValid = 1'b1; aInData = d2;
        tick();
        aInValid = 1'b0;
        lat = 3;
        while (!aOutValid && lat < 40) begin
            tick();
            lat++;
        end
        nChecks++; if (lat !== 16) $display("[TB] FAIL ignore_latency: got %0d want 16", lat); else nPassed++;
        nChecks++; if (aOutData !== exp1) $display("[TB] FAIL ignore_data: got %h want %h", aOutData, exp1); else nPassed++;
        releaseA();
        aOutReady = 1'b1;
        seen = 0;
        repeat (20) begin
            tick();
            if (aOutValid || !aInReady) seen++;
        end
        aOutReady = 1'b0;
        nChecks++; if (seen !== 0) $display("[TB] FAIL ignore_no_second_block: got %0d active cycles want 0", seen); else nPassed++;
    endtask

    task automatic test_back_to_back();
        logic [63:0] cur, nxt, exp;
        bInValid = 1'b1; bInData = 64'hFFFFFFFFFFFFFFFF; bFwd = 1'b0; bOutReady = 1'b1;
        tick();
        nChecks++; if (bBusy !== 1'b1 || bOutValid !== 1'b0) $display("[TB] FAIL l16_accept: busy %b valid %b want 1/0", bBusy, bOutValid); else nPassed++;
        cur = {$urandom(), $urandom()};
        bInData = cur;
        tick();
        nChecks++; if (bOutValid !== 1'b1 || bOutData !== 64'hAAAAAAAAAAAAAAAA) $display("[TB] FAIL l16_first: valid %b data %h want 1/aaaaaaaaaaaaaaaa", bOutValid, bOutData); else nPassed++;
        for (int i = 0; i < 6; i++) begin
            tick();
            nChecks++; if (bOutValid !== 1'b0 || bBusy !== 1'b1) $display("[TB] FAIL b2b_reload %0d: valid %b busy %b want 0/1", i, bOutValid, bBusy); else nPassed++;
            nxt = {$urandom(), $urandom()};
            bInData = nxt;
            exp = refSub(cur, bFwd);
            tick();
            nChecks++; if (bOutValid !== 1'b1 || bOutData !== exp) $display("[TB] FAIL b2b_data %0d: valid %b data %h want 1/%h", i, bOutValid, bOutData, exp); else nPassed++;
            cur = nxt;
        end
        bInValid = 1'b0;
        tick();
        nChecks++; if (bOutValid !== 1'b0 || bInReady !== 1'b1) $display("[TB] FAIL b2b_drain: valid %b ready %b want 0/1", bOutValid, bInReady); else nPassed++;
        bOutReady = 1'b0;
    endtask

`ifdef SBOX_SEQ_FWD_EN
    task automatic test_fwd_mode();
        logic [63:0] got, back;
        int          lat;
        runA(64'h0123456789ABCDEF, 1'b1, got, lat);
        nChecks++; if (got !== 64'hC56B90AD3EF84712) $display("[TB] FAIL fwd_data: got %h want c56b90ad3ef84712", got); else nPassed++;
        releaseA();
        runA(got, 1'b0, back, lat);
        nChecks++; if (back !== 64'h0123456789ABCDEF) $display("[TB] FAIL fwd_roundtrip: got %h want 0123456789abcdef", back); else nPassed++;
        releaseA();
    endtask
`endif

    initial begin
        test_reset();
        test_known_vector();
        test_random();
        test_stall_reload();
        test_reset_abort();
        test_ignore_in_sub();
        test_back_to_back();
`ifdef SBOX_SEQ_FWD_EN
        test_fwd_mode();
`endif
        $display("%0d/%0d checks passed", nPassed, nChecks);
        $finish;
    end

endmodule

// File: doc/sbox_decrypt_sequencer.md
Name: sbox_decrypt_sequencer

Overview:
Applies the 4-bit inverse substitution layer to a full 64-bit cipher state. It time-shares LANES nibble-wide inverse S-box lookups across the 16 nibbles of the block, LSB nibble first. It sits between the round-key/permutation stage and the next decrypt round. Valid/ready handshakes on both sides let the round controller stall it.

Parameters:
BLOCKSIZE, 64, state width in bits; fixed at 64 (16 nibbles).
LANES, 1, inverse S-box lookups per cycle; legal values 1, 2, 4, 8, 16; other values are an elaboration error.

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  asynchronous, active-high reset
in_valid  input  1  in_data is presented
in_ready  output  1  block can accept in_data this cycle
in_data  input  BLOCKSIZE  state to substitute
out_valid  output  1  out_data holds a completed result
out_ready  input  1  downstream accepts out_data
out_data  output  BLOCKSIZE  substituted state
busy  output  1  high in SUB state

Behaviour:
- Inverse table, nibble in -> out: 0->5 1->E 2->F 3->8 4->C 5->1 6->2 7->D 8->B 9->4 A->6 B->3 C->0 D->7 E->9 F->A.
- States: IDLE, SUB, DONE. Internal regs: work[63:0], grp counter of width clog2(16/LANES) (minimum 1 bit).
- Reset (asynchronous, any state): state=IDLE, work=0, grp=0, out_valid=0, busy=0, in_ready=1, out_data=0.
- in_ready = (state==IDLE) || (state==DONE && out_ready). An input handshake is in_valid && in_ready.
- IDLE: on handshake, load work<=in_data, grp<=0, go to SUB. in_data is ignored when in_valid=0.
- SUB: each cycle, substitute nibbles [grp*LANES .. grp*LANES+LANES-1] of work in place and increment grp. On the last group (grp == 16/LANES-1), grp wraps to 0 and state goes to DONE. in_valid is ignored in SUB; there is no preemption.
- Latency: out_valid rises exactly 16/LANES cycles after the accepting edge. This is 16 cycles for LANES=1 and 1 cycle for LANES=16.
- DONE: out_valid=1 and out_data=work, held stable until out_ready.
  - out_ready=1 and in_valid=1: complete the output and load the new input in the same cycle, go to SUB. Back-to-back throughput is one block per 16/LANES+1 cycles.
  - out_ready=1 and in_valid=0: go to IDLE.
  - out_ready=0: stay in DONE. in_ready=0.
- out_data is registered and equal to work. Between results it holds the last value, or 0 after reset.
- Reset asserted mid-SUB discards the partial block. No output is produced for it.

Optional Feature:
SBOX_SEQ_FWD_EN
- Defined: adds input port fwd (1 bit), sampled at the input handshake and held in a mode register for the whole block.
  - fwd=1 selects the forward table: 0->C 1->5 2->6 3->B 4->9 5->0 6->A 7->D 8->3 9->E A->F B->8 C->4 D->7 E->1 F->2.
  - fwd=0 selects the inverse table.
  - The mode register resets to 0.
- Undefined: no fwd port; the inverse table only.
- Timing and handshake are identical in both builds.

Test Plan:
1. LANES=1, reset, in_data=64'h0123456789ABCDEF accepted at edge T -> busy high for 16 cycles; out_valid high from edge T+16; out_data=64'h5EF8C12DB463079A.
2. LANES=16, in_data=64'hFFFFFFFFFFFFFFFF -> out_valid one cycle after accept; out_data=64'hAAAAAAAAAAAAAAAA.
3. Hold out_ready=0 for 5 cycles in DONE -> out_valid, out_data stable, in_ready=0. Then out_ready=1 with in_valid=1, in_data=64'h0 -> same-edge reload; next result 64'h5555555555555555.
4. Assert reset after 7 SUB cycles -> out_valid=0, in_ready=1, out_data=0 immediately (asynchronous). No result ever appears for the aborted block.
5. in_valid pulsed during SUB with a different in_data -> ignored; the result matches the first block only.
6. SBOX_SEQ_FWD_EN, fwd=1, in_data=64'h0123456789ABCDEF -> out_data=64'hC56B90AD3EF84712. Feed that result back with fwd=0 -> 64'h0123456789ABCDEF.
